// File: rtl/serial_cmd_rx_pkg.sv
// Shared types and helpers for the host-to-AGC serial command receiver.
// Frame layout on the wire: SYNC, ID, DHI, DLO, CSUM (CSUM = ID ^ DHI ^ DLO).
package serial_cmd_rx_pkg;

  localparam logic [7:0] SERIAL_SYNC = 8'hA5;

  typedef enum logic [7:0] {
    NO_REG       = 8'h00,
    VERB         = 8'h01,
    NOUN         = 8'h02,
    MISSION_TIME = 8'h03,
    APOGEE       = 8'h04,
    PERIGEE      = 8'h05
  } serial_reg_id_t;

  typedef enum logic [2:0] {
    P_IDLE = 3'd0,
    P_ID   = 3'd1,
    P_DHI  = 3'd2,
    P_DLO  = 3'd3,
    P_CSUM = 3'd4
  } parse_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic logic [7:0] calc_csum(input logic [7:0] id,
                                           input logic [7:0] dhi,
                                           input logic [7:0] dlo);
    return id ^ dhi ^ dlo;
  endfunction

  function automatic logic id_in_range(input logic [7:0] id);
    return (id >= 8'h01) && (id <= 8'h05);
  endfunction

endpackage

// File: rtl/serial_cmd_rx_uart_rx_byte.sv
// 8N1 byte receiver: rx synchroniser, oversample tick generator and bit-level FSM.
// Emits one-cycle byte_valid / byte_err pulses, both registered.
module uart_rx_byte
  import serial_cmd_rx_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_rx,
  output logic       o_tick,
  output logic       o_byte_valid,
  output logic [7:0] o_byte_data,
  output logic       o_byte_err
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick;
  rx_state_t        r_state;
  logic [OS_W-1:0]  r_os_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_valid;
  logic             r_err;
  logic [7:0]       r_data;

  // Two-flop synchroniser plus one delay stage for falling-edge detection; idles high.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= i_rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // Free-running oversample tick, one pulse every DIV clocks.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
      r_tick    <= 1'b0;
    end
  end

  // Bit-level receive FSM; samples at mid-bit using the oversample count.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= RX_IDLE;
      r_os_cnt  <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          r_os_cnt  <= '0;
          r_bit_idx <= 3'd0;
          if (r_rx_prev && !r_sync2) begin
            r_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_tick) begin
            if (r_os_cnt == OS_HALF) begin
              r_os_cnt <= '0;
              r_state  <= r_sync2 ? RX_IDLE : RX_DATA;
            end else begin
              r_os_cnt <= r_os_cnt + OS_W'(1);
            end
          end
        end
        RX_DATA: begin
          if (r_tick) begin
            if (r_os_cnt == OS_LAST) begin
              r_os_cnt  <= '0;
              r_shift   <= {r_sync2, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_state <= RX_STOP;
              end
            end else begin
              r_os_cnt <= r_os_cnt + OS_W'(1);
            end
          end
        end
        RX_STOP: begin
          if (r_tick) begin
            if (r_os_cnt == OS_LAST) begin
              r_os_cnt <= '0;
              r_state  <= RX_IDLE;
              if (r_sync2) begin
                r_valid <= 1'b1;
                r_data  <= r_shift;
              end else begin
                r_err <= 1'b1;
              end
            end else begin
              r_os_cnt <= r_os_cnt + OS_W'(1);
            end
          end
        end
        default: begin
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign o_tick       = r_tick;
  assign o_byte_valid = r_valid;
  assign o_byte_data  = r_data;
  assign o_byte_err   = r_err;

endmodule

// File: rtl/serial_cmd_rx.sv
// Host-to-AGC serial command receiver: parses SYNC/ID/DHI/DLO/CSUM frames from the UART
// byte stream and writes one of five 15-bit CPU-readable input registers per valid frame.
module serial_cmd_rx
  import serial_cmd_rx_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BAUD         = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx,
  output logic [14:0] DSKY_VERB_data,
  output logic [14:0] DSKY_NOUN_data,
  output logic [14:0] AXI_MISSION_TIME_data,
  output logic [14:0] AXI_APOGEE_data,
  output logic [14:0] AXI_PERIGEE_data,
  output logic [4:0]  reg_updated,
  output logic        frame_err,
  output logic        byte_err
);

  localparam int TO_TICKS = TIMEOUT_BITS * OVERSAMPLE;
  localparam int TO_W     = $clog2(TO_TICKS);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_TICKS - 1);

  logic       w_tick;
  logic       w_byte_valid;
  logic [7:0] w_byte_data;
  logic       w_byte_err;
  logic       w_to_expire;

  parse_state_t   r_state;
  serial_reg_id_t r_id;
  logic [6:0]     r_dhi;
  logic [7:0]     r_dlo;
  logic [TO_W-1:0] r_to_cnt;
  logic [14:0]    r_verb;
  logic [14:0]    r_noun;
  logic [14:0]    r_mission_time;
  logic [14:0]    r_apogee;
  logic [14:0]    r_perigee;
  logic [4:0]     r_upd;
  logic           r_frame_err;
  logic           r_byte_err;

  uart_rx_byte #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rx (
    .i_clock     (clock),
    .i_reset_n   (reset_n),
    .i_rx        (rx),
    .o_tick      (w_tick),
    .o_byte_valid(w_byte_valid),
    .o_byte_data (w_byte_data),
    .o_byte_err  (w_byte_err)
  );

  assign w_to_expire = (r_state != P_IDLE) && w_tick && (r_to_cnt == TO_LAST);

  // Inter-byte timeout: held at zero while idle, restarted by every received byte.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else if (w_byte_valid || (r_state == P_IDLE)) begin
      r_to_cnt <= '0;
    end else if (w_tick) begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  // Frame parser with registered register file and status pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= P_IDLE;
      r_id           <= NO_REG;
      r_dhi          <= 7'd0;
      r_dlo          <= 8'h00;
      r_verb         <= 15'd0;
      r_noun         <= 15'd0;
      r_mission_time <= 15'd0;
      r_apogee       <= 15'd0;
      r_perigee      <= 15'd0;
      r_upd          <= 5'd0;
      r_frame_err    <= 1'b0;
      r_byte_err     <= 1'b0;
    end else begin
      r_upd       <= 5'd0;
      r_frame_err <= 1'b0;
      r_byte_err  <= w_byte_err;
      if (w_byte_err) begin
        r_frame_err <= (r_state != P_IDLE);
        r_state     <= P_IDLE;
      end else if (w_to_expire) begin
        // A byte landing on the expiry cycle starts the next frame search.
        r_frame_err <= 1'b1;
        r_state     <= (w_byte_valid && (w_byte_data == SERIAL_SYNC)) ? P_ID : P_IDLE;
      end else if (w_byte_valid) begin
        case (r_state)
          P_IDLE: begin
            if (w_byte_data == SERIAL_SYNC) begin
              r_state <= P_ID;
            end
          end
          P_ID: begin
            if (id_in_range(w_byte_data)) begin
              r_id    <= serial_reg_id_t'(w_byte_data);
              r_state <= P_DHI;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= P_IDLE;
            end
          end
          P_DHI: begin
            if (w_byte_data[7]) begin
              r_frame_err <= 1'b1;
              r_state     <= P_IDLE;
            end else begin
              r_dhi   <= w_byte_data[6:0];
              r_state <= P_DLO;
            end
          end
          P_DLO: begin
            r_dlo   <= w_byte_data;
            r_state <= P_CSUM;
          end
          P_CSUM: begin
            r_state <= P_IDLE;
            if (w_byte_data == calc_csum(r_id, {1'b0, r_dhi}, r_dlo)) begin
              case (r_id)
                VERB: begin
                  r_verb <= {r_dhi, r_dlo};
                  r_upd  <= 5'b00001;
                end
                NOUN: begin
                  r_noun <= {r_dhi, r_dlo};
                  r_upd  <= 5'b00010;
                end
                MISSION_TIME: begin
                  r_mission_time <= {r_dhi, r_dlo};
                  r_upd          <= 5'b00100;
                end
                APOGEE: begin
                  r_apogee <= {r_dhi, r_dlo};
                  r_upd    <= 5'b01000;
                end
                PERIGEE: begin
                  r_perigee <= {r_dhi, r_dlo};
                  r_upd     <= 5'b10000;
                end
                default: begin
                  r_frame_err <= 1'b1;
                end
              endcase
            end else begin
              r_frame_err <= 1'b1;
            end
          end
          default: begin
            r_state <= P_IDLE;
          end
        endcase
      end
    end
  end

  assign DSKY_VERB_data        = r_verb;
  assign DSKY_NOUN_data        = r_noun;
  assign AXI_MISSION_TIME_data = r_mission_time;
  assign AXI_APOGEE_data       = r_apogee;
  assign AXI_PERIGEE_data      = r_perigee;
  assign reg_updated           = r_upd;
  assign frame_err             = r_frame_err;
  assign byte_err              = r_byte_err;

endmodule

// File: tb/tb_serial_cmd_rx.sv
// Directed bench for serial_cmd_rx, run at a fast baud (DIV=4, 64 clocks per bit)
// so every frame scenario fits in a short simulation.
module tb_serial_cmd_rx;

  localparam int CLK_HZ  = 50_000_000;
  localparam int BAUD    = 781_250;
  localparam int OS      = 16;
  localparam int TO_BITS = 40;
  localparam int BIT     = 64;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [14:0] verb, noun, mtime, apogee, perigee;
  logic [4:0]  reg_updated;
  logic        frame_err, byte_err;

  int n_checks = 0;
  int n_pass   = 0;

  int m_ferr = 0, m_berr = 0, m_both = 0, m_upd_cycles = 0, m_upd_pulses = 0;
  int m_upd [5] = '{0, 0, 0, 0, 0};
  logic [4:0] m_prev_upd = 5'd0;

  int s_ferr, s_berr, s_both, s_upd_cycles, s_upd_pulses;
  int s_upd [5];

  always #10 clock = ~clock;

  serial_cmd_rx #(
    .CLK_HZ      (CLK_HZ),
    .BAUD        (BAUD),
    .OVERSAMPLE  (OS),
    .TIMEOUT_BITS(TO_BITS)
  ) dut (
    .clock                (clock),
    .reset_n              (reset_n),
    .rx                   (rx),
    .DSKY_VERB_data       (verb),
    .DSKY_NOUN_data       (noun),
    .AXI_MISSION_TIME_data(mtime),
    .AXI_APOGEE_data      (apogee),
    .AXI_PERIGEE_data     (perigee),
    .reg_updated          (reg_updated),
    .frame_err            (frame_err),
    .byte_err             (byte_err)
  );

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (frame_err) m_ferr++;
    if (byte_err) m_berr++;
    if (frame_err && byte_err) m_both++;
    if (reg_updated != 5'd0) begin
      m_upd_cycles++;
      if (m_prev_upd == 5'd0) m_upd_pulses++;
    end
    for (int i = 0; i < 5; i++) if (reg_updated[i]) m_upd[i]++;
    m_prev_upd = reg_updated;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic snap();
    s_ferr = m_ferr; s_berr = m_berr; s_both = m_both;
    s_upd_cycles = m_upd_cycles; s_upd_pulses = m_upd_pulses;
    for (int i = 0; i < 5; i++) s_upd[i] = m_upd[i];
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BIT) @(posedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BIT) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(posedge clock);
    end
    rx = stop_bit;
    repeat (BIT) @(posedge clock);
    rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
    send_byte(b3, 1'b1);
    send_byte(b4, 1'b1);
    idle_bits(2);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_verb"}, 32'(verb), 32'h0);
    check_val({tag, "_noun"}, 32'(noun), 32'h0);
    check_val({tag, "_mtime"}, 32'(mtime), 32'h0);
    check_val({tag, "_apogee"}, 32'(apogee), 32'h0);
    check_val({tag, "_perigee"}, 32'(perigee), 32'h0);
    check_val({tag, "_upd"}, 32'(reg_updated), 32'h0);
    check_val({tag, "_ferr"}, 32'(frame_err), 32'h0);
    check_val({tag, "_berr"}, 32'(byte_err), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle_bits(2);

    // Valid VERB frame
    snap();
    send_frame(8'hA5, 8'h01, 8'h00, 8'h23, 8'h22);
    check_val("t1_verb", 32'(verb), 32'h0023);
    check_val("t1_upd0", 32'(m_upd[0] - s_upd[0]), 32'd1);
    check_val("t1_upd_cycles", 32'(m_upd_cycles - s_upd_cycles), 32'd1);
    check_val("t1_upd_pulses", 32'(m_upd_pulses - s_upd_pulses), 32'd1);
    check_val("t1_noun", 32'(noun), 32'h0);
    check_val("t1_mtime", 32'(mtime), 32'h0);
    check_val("t1_apogee", 32'(apogee), 32'h0);
    check_val("t1_perigee", 32'(perigee), 32'h0);
    check_val("t1_ferr", 32'(m_ferr - s_ferr), 32'd0);

    // Full-scale APOGEE, then a checksum mismatch for NOUN
    snap();
    send_frame(8'hA5, 8'h04, 8'h7F, 8'hFF, 8'h84);
    check_val("t2_apogee", 32'(apogee), 32'h7FFF);
    check_val("t2_upd3", 32'(m_upd[3] - s_upd[3]), 32'd1);
    snap();
    send_frame(8'hA5, 8'h02, 8'h00, 8'h10, 8'h00);
    check_val("t2_csum_ferr", 32'(m_ferr - s_ferr), 32'd1);
    check_val("t2_csum_noun", 32'(noun), 32'h0);
    check_val("t2_csum_upd", 32'(m_upd_cycles - s_upd_cycles), 32'd0);

    // Bad ID, then DHI with bit 7 set
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h06, 1'b1);
    idle_bits(2);
    check_val("t3_id_ferr", 32'(m_ferr - s_ferr), 32'd1);
    send_frame(8'hA5, 8'h01, 8'h80, 8'h00, 8'h81);
    check_val("t3_dhi_ferr", 32'(m_ferr - s_ferr), 32'd2);
    check_val("t3_verb", 32'(verb), 32'h0023);
    check_val("t3_upd", 32'(m_upd_cycles - s_upd_cycles), 32'd0);

    // Low stop bit on DLO, then recovery on PERIGEE
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h23, 1'b0);
    idle_bits(2);
    check_val("t4_berr", 32'(m_berr - s_berr), 32'd1);
    check_val("t4_ferr", 32'(m_ferr - s_ferr), 32'd1);
    check_val("t4_same_cycle", 32'(m_both - s_both), 32'd1);
    check_val("t4_verb", 32'(verb), 32'h0023);
    snap();
    send_frame(8'hA5, 8'h05, 8'h12, 8'h34, 8'h23);
    check_val("t4_perigee", 32'(perigee), 32'h1234);
    check_val("t4_upd4", 32'(m_upd[4] - s_upd[4]), 32'd1);

    // Inter-byte timeout, then a clean MISSION_TIME frame
    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    idle_bits(TO_BITS + 2);
    check_val("t5_timeout_ferr", 32'(m_ferr - s_ferr), 32'd1);
    snap();
    send_frame(8'hA5, 8'h03, 8'h01, 8'h00, 8'h02);
    check_val("t5_mtime", 32'(mtime), 32'h0100);
    check_val("t5_upd2", 32'(m_upd[2] - s_upd[2]), 32'd1);
    check_val("t5_ferr", 32'(m_ferr - s_ferr), 32'd0);

    // Reset during the DHI byte of a NOUN frame
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    fork
      begin
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h57, 1'b1);
      end
      begin
        repeat (3 * BIT) @(posedge clock);
        reset_n = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check_all_zero("t6_in_reset");
        reset_n = 1'b1;
      end
    join
    snap();
    idle_bits(3);
    check_val("t6_noun", 32'(noun), 32'h0);
    check_val("t6_upd", 32'(m_upd_cycles - s_upd_cycles), 32'd0);

    // 200 ns low glitch on an idle line
    idle_bits(2);
    snap();
    rx = 1'b0;
    repeat (10) @(posedge clock);
    rx = 1'b1;
    idle_bits(3);
    check_val("t6_glitch_ferr", 32'(m_ferr - s_ferr), 32'd0);
    check_val("t6_glitch_berr", 32'(m_berr - s_berr), 32'd0);
    check_val("t6_glitch_upd", 32'(m_upd_cycles - s_upd_cycles), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
